// File: rtl/alu_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_bist                                                        |
// | Purpose  : BIST initiator for the MIPS ALU. Applies vectors, checks the    |
// |            result/zero flag against a golden model, reports errors.        |
// | Option   : ALU_BIST_LFSR_EN adds NUM_RAND pseudorandom vectors.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu_bist #(
    parameter int WIDTH    = 32,
    parameter int SETTLE   = 1,
    parameter int NUM_RAND = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] srca,
    output logic [WIDTH-1:0] srcb,
    output logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] aluresult,
    input  logic             zero,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [7:0]       fail_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_APPLY = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int NUM_DIR = 10;
`ifdef ALU_BIST_LFSR_EN
    localparam int          NUM_VEC   = NUM_DIR + NUM_RAND;
    localparam int          IDX_W     = 16;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2024;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
`else
    // The random stage is absent; NUM_RAND is kept so both builds share one interface.
    localparam int NUM_VEC = NUM_DIR + (NUM_RAND * 0);
    localparam int IDX_W   = 4;
`endif
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [2:0]       state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] srca_q,   srca_d;
    logic [WIDTH-1:0] srcb_q,   srcb_d;
    logic [2:0]       op_q,     op_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             pass_q,   pass_d;
    logic [7:0]       err_q,    err_d;
    logic [7:0]       fail_q,   fail_d;

    logic [WIDTH-1:0] dir_a;
    logic [WIDTH-1:0] dir_b;
    logic [2:0]       dir_op;
    logic [WIDTH-1:0] exp_res;
    logic             mismatch;

    // Table values are 32-bit two's complement; sign-extend so -1 stays -1 at any WIDTH.
    function automatic logic [WIDTH-1:0] sx(input logic [31:0] v);
        return WIDTH'($signed(v));
    endfunction

    function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0]       op);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        dir_a  = '0;
        dir_b  = '0;
        dir_op = OP_AND;
        case (idx_q)
            IDX_W'(0): begin dir_op = OP_ADD; dir_a = sx(32'd23);         dir_b = sx(32'd45);         end
            IDX_W'(1): begin dir_op = OP_ADD; dir_a = sx(32'hFFFF_FFFF);  dir_b = sx(32'd99);         end
            IDX_W'(2): begin dir_op = OP_SUB; dir_a = sx(32'd44);         dir_b = sx(32'd45);         end
            IDX_W'(3): begin dir_op = OP_AND; dir_a = sx(32'd256);        dir_b = sx(32'd255);        end
            IDX_W'(4): begin dir_op = OP_OR;  dir_a = sx(32'd257);        dir_b = sx(32'd255);        end
            IDX_W'(5): begin dir_op = OP_SLT; dir_a = sx(32'd1);          dir_b = sx(32'd0);          end
            IDX_W'(6): begin dir_op = OP_SLT; dir_a = sx(32'hFFFF_FFFF);  dir_b = sx(32'd0);          end
            IDX_W'(7): begin dir_op = OP_SLT; dir_a = sx(32'd0);          dir_b = sx(32'hFFFF_FFFF);  end
            IDX_W'(8): begin dir_op = OP_SLT; dir_a = sx(32'hFFFF_FFC1);  dir_b = sx(32'hFFFF_FF81);  end
            IDX_W'(9): begin dir_op = OP_SLT; dir_a = sx(32'd3);          dir_b = sx(32'd5);          end
            default:   begin dir_op = OP_AND; dir_a = '0;                 dir_b = '0;                 end
        endcase
    end

`ifdef ALU_BIST_LFSR_EN
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] lfsr_s1, lfsr_s2;
    logic [2:0]  opsel_q, opsel_d;
    logic [2:0]  rand_op;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    assign lfsr_s1 = lfsr_step(lfsr_q);
    assign lfsr_s2 = lfsr_step(lfsr_s1);

    // opsel tracks idx mod 5 without a divider.
    always_comb begin
        case (opsel_q)
            3'd0:    rand_op = OP_AND;
            3'd1:    rand_op = OP_OR;
            3'd2:    rand_op = OP_ADD;
            3'd3:    rand_op = OP_SUB;
            default: rand_op = OP_SLT;
        endcase
    end
`endif

    assign exp_res  = golden(srca_q, srcb_q, op_q);
    assign mismatch = (aluresult != exp_res) | (zero != (exp_res == '0));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
`ifdef ALU_BIST_LFSR_EN
        lfsr_d  = lfsr_q;
        opsel_d = opsel_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_APPLY;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 8'h00;
                    fail_d  = 8'hFF;
`ifdef ALU_BIST_LFSR_EN
                    lfsr_d  = LFSR_SEED;
                    opsel_d = 3'd0;
`endif
                end
            end
            S_APPLY: begin
                srca_d  = dir_a;
                srcb_d  = dir_b;
                op_d    = dir_op;
`ifdef ALU_BIST_LFSR_EN
                if (idx_q >= IDX_W'(NUM_DIR)) begin
                    srca_d = WIDTH'(lfsr_s1);
                    srcb_d = WIDTH'(lfsr_s2);
                    op_d   = rand_op;
                    lfsr_d = lfsr_s2;
                end
`endif
                cnt_d   = CNT_W'(SETTLE - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (fail_q == 8'hFF) begin
`ifdef ALU_BIST_LFSR_EN
                        fail_d = (idx_q >= 16'd254) ? 8'hFE : idx_q[7:0];
`else
                        fail_d = 8'(idx_q);
`endif
                    end
                end
                if (idx_q == IDX_W'(NUM_VEC - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 8'h00);
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_APPLY;
`ifdef ALU_BIST_LFSR_EN
                    opsel_d = (opsel_q == 3'd4) ? 3'd0 : opsel_q + 3'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            srca_q  <= '0;
            srcb_q  <= '0;
            op_q    <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 8'h00;
            fail_q  <= 8'hFF;
`ifdef ALU_BIST_LFSR_EN
            lfsr_q  <= LFSR_SEED;
            opsel_q <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
`ifdef ALU_BIST_LFSR_EN
            lfsr_q  <= lfsr_d;
            opsel_q <= opsel_d;
`endif
        end
    end

    assign srca       = srca_q;
    assign srcb       = srcb_q;
    assign alucontrol = op_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_idx   = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_bist                                                     |
// | Purpose  : Directed bench for alu_bist with a behavioural ALU that can     |
// |            carry an unsigned-SLT or stuck-zero fault.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu_bist;

`ifdef ALU_BIST_LFSR_EN
    localparam int SETTLE   = 2;
    localparam int NUM_RAND = 64;
    localparam int NVEC     = 10 + NUM_RAND;
`else
    localparam int SETTLE   = 1;
    localparam int NUM_RAND = 64;
    localparam int NVEC     = 10;
`endif
    localparam int P        = SETTLE + 2;
    localparam int DONE_CYC = NVEC * P + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] srca, srcb, aluresult;
    logic [2:0]  alucontrol;
    logic        zero, busy, done, pass;
    logic [7:0]  err_count, fail_idx;

    int alu_mode;
    int checks   = 0;
    int failures = 0;

    logic [31:0] t_a  [10] = '{32'd23, 32'hFFFF_FFFF, 32'd44, 32'd256, 32'd257,
                               32'd1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFC1, 32'd3};
    logic [31:0] t_b  [10] = '{32'd45, 32'd99, 32'd45, 32'd255, 32'd255,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF81, 32'd5};
    logic [2:0]  t_op [10] = '{3'b010, 3'b010, 3'b110, 3'b000, 3'b001,
                               3'b111, 3'b111, 3'b111, 3'b111, 3'b111};

    always #5 clk = ~clk;

    alu_bist #(.WIDTH(32), .SETTLE(SETTLE), .NUM_RAND(NUM_RAND)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .srca       (srca),
        .srcb       (srcb),
        .alucontrol (alucontrol),
        .aluresult  (aluresult),
        .zero       (zero),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_idx   (fail_idx)
    );

    // Mode 1: SLT compares unsigned. Mode 2: zero flag stuck at 0.
    always_comb begin
        aluresult = 32'h0;
        case (alucontrol)
            3'b000:  aluresult = srca & srcb;
            3'b001:  aluresult = srca | srcb;
            3'b010:  aluresult = srca + srcb;
            3'b110:  aluresult = srca - srcb;
            3'b111:  aluresult = (alu_mode == 1) ? {31'b0, (srca < srcb)}
                                                 : {31'b0, ($signed(srca) < $signed(srcb))};
            default: aluresult = 32'h0;
        endcase
        zero = (alu_mode == 2) ? 1'b0 : (aluresult == 32'h0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef ALU_BIST_LFSR_EN
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [2:0] rand_op(input int k);
        logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        return ops[k % 5];
    endfunction
`endif

    // Pulses start while the TB sits 1 time unit after an edge; cycle 1 is the
    // first cycle after start was sampled. exp_err < 0 skips the count check.
    task automatic run(input int mode, input bit chk_vec, input int pulse_at,
                       input int exp_err, input logic [7:0] exp_fidx);
        int k;
        logic [31:0] ls;
        ls = 32'hACE1_2024;
        alu_mode = mode;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr", err_count, 0);
        check("start_fidx_clr", fail_idx, 8'hFF);
        for (int c = 1; c < DONE_CYC; c++) begin
            if (chk_vec && (c % P) == 2) begin
                k = c / P;
                if (k < 10) begin
                    check($sformatf("vec%0d_a", k), srca, t_a[k]);
                    check($sformatf("vec%0d_b", k), srcb, t_b[k]);
                    check($sformatf("vec%0d_op", k), alucontrol, t_op[k]);
                end
`ifdef ALU_BIST_LFSR_EN
                else begin
                    ls = lfsr_step(ls);
                    check($sformatf("rvec%0d_a", k), srca, ls);
                    ls = lfsr_step(ls);
                    check($sformatf("rvec%0d_b", k), srcb, ls);
                    check($sformatf("rvec%0d_op", k), alucontrol, rand_op(k));
                end
`endif
            end
            if (c == DONE_CYC - 1) begin
                check("done_not_early", done, 0);
            end
            start = (c == pulse_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_at_cycle", done, 1);
        check("busy_at_done", busy, 0);
        check("pass", pass, (exp_err == 0) ? 1 : 0);
        if (exp_err >= 0) begin
            check("err_count", err_count, exp_err);
        end
        check("fail_idx", fail_idx, exp_fidx);
        repeat (2) @(posedge clk);
        #1;
        check("done_held", done, 1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        alu_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_fidx", fail_idx, 8'hFF);
        check("rst_srca", srca, 0);
        check("rst_op", alucontrol, 0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rst_beats_start", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run(0, 1'b1, -1, 0, 8'hFF);
`ifdef ALU_BIST_LFSR_EN
        run(1, 1'b0, -1, -1, 8'd6);
        run(2, 1'b0, -1, -1, 8'd3);
`else
        run(1, 1'b0, -1, 2, 8'd6);
        run(2, 1'b0, -1, 4, 8'd3);
`endif
        run(0, 1'b0, 5, 0, 8'hFF);

        // Reset during cycle 12 of a faulty run.
        alu_mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err_count, 0);
        check("midrst_fidx", fail_idx, 8'hFF);
        check("midrst_srca", srca, 0);
        check("midrst_srcb", srcb, 0);
        @(posedge clk); #1;
        run(0, 1'b1, -1, 0, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
